key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 145 ++++++++++++++
 tb/tb_key_conditioner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: per-channel synchroniser, debouncer and press/release/long-press pulse generator.
module key_conditioner #(
  parameter int unsigned N_KEYS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned LONG_CYCLES     = 2000000,
  parameter int unsigned ACTIVE_LOW_KEYS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_p,
  output logic [N_KEYS-1:0] release_p,
  output logic [N_KEYS-1:0] long_p
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [N_KEYS-1:0] SYNC_RST  = (ACTIVE_LOW_KEYS != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] k_s;

  // Two-flop synchroniser; resets to the pad's released level so no false press appears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign k_s = (ACTIVE_LOW_KEYS != 0) ? ~sync2 : sync2;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        hold_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        hold_q    <= hold_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    // Debounce FSM; hold time keeps running through release glitches so long-press timing is stable.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;

      if ((state_q == HELD || state_q == RELEASE_WAIT) && hold_q != LONG_MAX) begin
        hold_d = hold_q + HOLD_W'(1);
        long_d = (hold_q == LONG_LAST);
      end

      case (state_q)
        IDLE: begin
          if (k_s[g]) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!k_s[g]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            hold_d  = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!k_s[g]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (k_s[g]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            hold_d    = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
            long_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    assign key_level[g] = level_q;
    assign press_p[g]   = press_q;
    assign release_p[g] = release_q;
    assign long_p[g]    = long_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed vector table, hand sequences and randomized run against a run-length model.
module tb_key_conditioner;

  localparam int unsigned N  = 3;
  localparam int unsigned D  = 4;
  localparam int unsigned L  = 10;
  localparam int unsigned AL = 1;

  logic         clk;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_level;
  logic [N-1:0] press_p;
  logic [N-1:0] release_p;
  logic [N-1:0] long_p;

  int n_chk  = 0;
  int n_fail = 0;

  key_conditioner #(
    .N_KEYS(N),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .ACTIVE_LOW_KEYS(AL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .key_level(key_level),
    .press_p(press_p),
    .release_p(release_p),
    .long_p(long_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pad delay line, per-channel run length of disagreeing samples, time since press.
  logic [N-1:0] m_d1, m_d2;
  logic [N-1:0] m_lvl, m_press, m_rel, m_long;
  int           run   [N];
  int           since [N];

  typedef struct {
    logic [N-1:0] keys;
    int           edges;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [N-1:0] k, input int e, input logic [N-1:0] lv,
                     input logic [N-1:0] pr, input logic [N-1:0] re, input logic [N-1:0] lo);
    vec_t v;
    v.keys = k; v.edges = e; v.lvl = lv; v.prs = pr; v.rel = re; v.lng = lo;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = (AL != 0) ? '1 : '0;
    m_d2 = m_d1;
    m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < N; c++) begin
      run[c]   = 0;
      since[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] ks;
    if (!rst) begin
      model_reset();
      return;
    end
    ks = (AL != 0) ? ~m_d2 : m_d2;
    m_d2 = m_d1;
    m_d1 = key_in;
    m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < N; c++) begin
      if (ks[c] != m_lvl[c]) run[c]++;
      else run[c] = 0;
      if (run[c] == int'(D)) begin
        run[c] = 0;
        m_lvl[c] = ks[c];
        if (ks[c]) begin
          m_press[c] = 1'b1;
          since[c]   = 0;
        end else begin
          m_rel[c] = 1'b1;
        end
      end else if (m_lvl[c]) begin
        since[c]++;
        if (since[c] == int'(L)) m_long[c] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] keys);
    key_in = keys;
    @(posedge clk);
    model_edge();
    #1;
    chk("model key_level", key_level, m_lvl);
    chk("model press_p", press_p, m_press);
    chk("model release_p", release_p, m_rel);
    chk("model long_p", long_p, m_long);
  endtask

  task automatic chk_all(input string name, input logic [N-1:0] lv, input logic [N-1:0] pr,
                         input logic [N-1:0] re, input logic [N-1:0] lo);
    chk({name, " key_level"}, key_level, lv);
    chk({name, " press_p"}, press_p, pr);
    chk({name, " release_p"}, release_p, re);
    chk({name, " long_p"}, long_p, lo);
  endtask

  logic [N-1:0] rkeys;
  int           rem [N];

  initial begin
    rst    = 1'b0;
    key_in = '1;
    model_reset();
    #12;
    chk_all("reset", '0, '0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed vectors: keys, edges to advance, expected outputs after the last edge.
    add(3'b111, 3, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b110, 5, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b110, 1, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b110, 1, 3'b001, 3'b000, 3'b000, 3'b000);
    add(3'b110, 8, 3'b001, 3'b000, 3'b000, 3'b000);
    add(3'b110, 1, 3'b001, 3'b000, 3'b000, 3'b001);
    add(3'b110, 1, 3'b001, 3'b000, 3'b000, 3'b000);
    add(3'b110, 9, 3'b001, 3'b000, 3'b000, 3'b000);
    add(3'b111, 5, 3'b001, 3'b000, 3'b000, 3'b000);
    add(3'b111, 1, 3'b000, 3'b000, 3'b001, 3'b000);
    add(3'b111, 1, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b101, 2, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b111, 1, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b101, 5, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b101, 1, 3'b010, 3'b010, 3'b000, 3'b000);
    add(3'b111, 6, 3'b000, 3'b000, 3'b010, 3'b000);
    add(3'b110, 6, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b110, 2, 3'b001, 3'b000, 3'b000, 3'b000);
    add(3'b111, 2, 3'b001, 3'b000, 3'b000, 3'b000);
    add(3'b110, 5, 3'b001, 3'b000, 3'b000, 3'b000);
    add(3'b110, 1, 3'b001, 3'b000, 3'b000, 3'b001);
    add(3'b111, 6, 3'b000, 3'b000, 3'b001, 3'b000);
    add(3'b010, 6, 3'b101, 3'b101, 3'b000, 3'b000);
    add(3'b111, 6, 3'b000, 3'b000, 3'b101, 3'b000);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int e = 0; e < tbl[i].edges; e++) step(tbl[i].keys);
      chk_all($sformatf("row%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].lng);
    end

    // Reset with key 0 held and key 2 mid-debounce, keys kept pressed across deassertion.
    for (int e = 0; e < 6; e++) step(3'b110);
    chk_all("pre-reset held", 3'b001, 3'b001, 3'b000, 3'b000);
    for (int e = 0; e < 4; e++) step(3'b010);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk_all("async reset", '0, '0, '0, '0);
    step(3'b010);
    step(3'b010);
    rst = 1'b1;
    for (int e = 0; e < 5; e++) step(3'b010);
    chk_all("post-reset edge5", 3'b000, 3'b000, 3'b000, 3'b000);
    step(3'b010);
    chk_all("post-reset edge6", 3'b101, 3'b101, 3'b000, 3'b000);
    for (int e = 0; e < 8; e++) step(3'b111);

    // Randomized segments of random length per channel, with occasional resets.
    rkeys = '1;
    for (int c = 0; c < N; c++) rem[c] = 0;
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          rkeys[c] = ~rkeys[c];
          rem[c]   = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(12, 30))
                                                   : int'($urandom_range(1, 8));
        end
        rem[c]--;
      end
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        chk_all("random reset", '0, '0, '0, '0);
        step(rkeys);
        rst = 1'b1;
      end else begin
        step(rkeys);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
